riscv_fetch_stage: RTL and testbench

//  Instruction-fetch stage for the pipelined RISC-V core; sits upstream of decode/branch-execute.

---
 rtl/riscv_pkg.sv | 42 ++++
 rtl/riscv_if_id_reg.sv | 50 +++++
 rtl/riscv_fetch_stage.sv | 199 +++++++++++++++++++
 tb/tb_riscv_fetch_stage.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V core front end.
package riscv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned INSTR_W   = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0]    PC_STEP   = 32'd4;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_SKID  = 2'd1,
        S_DROP  = 2'd2
    } fetch_state_e;

    // Next-PC source selection.
    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2
    } pc_sel_e;

    // Next request-address source selection.
    typedef enum logic [1:0] {
        RA_HOLD  = 2'd0,
        RA_INC   = 2'd1,
        RA_REDIR = 2'd2,
        RA_PC    = 2'd3
    } req_sel_e;

    // Instruction word together with the address it was fetched from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } fetch_pkt_t;

    // Clear the byte-offset bits so a redirect target is always word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/riscv_if_id_reg.sv
// IF/ID pipeline register: valid bit, instruction, PC and precomputed PC+4.
module riscv_if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic               i_valid,
    input  fetch_pkt_t         i_pkt,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [XLEN-1:0]    o_pc,
    output logic [XLEN-1:0]    o_pc_plus4
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_pc_plus4;
    logic [XLEN-1:0]    w_pc_plus4_d;

    // PC+4 is computed on entry so decode sees it as a plain register output.
    assign w_pc_plus4_d = i_pkt.pc + PC_STEP;

    // Clear only drops the valid bit; payload keeps its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_pc       <= RESET_PC;
            r_pc_plus4 <= RESET_PC + PC_STEP;
        end else if (i_clear) begin
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_valid    <= i_valid;
            r_instr    <= i_pkt.instr;
            r_pc       <= i_pkt.pc;
            r_pc_plus4 <= w_pc_plus4_d;
        end
    end

    assign o_valid    = r_valid;
    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/riscv_fetch_stage.sv
// Instruction-fetch stage: PC ownership, variable-latency imem port, skid buffer,
// redirect handling with wrong-path drop, and the IF/ID register.
module riscv_fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_addr;
    fetch_pkt_t      r_skid;
    logic            r_skid_valid;

    logic            w_imem_req;
    logic            w_ack;
    logic [XLEN-1:0] w_pc_inc;
    logic [XLEN-1:0] w_redir_pc;

    pc_sel_e         w_pc_sel;
    req_sel_e        w_req_sel;
    logic            w_id_load;
    logic            w_id_clear;
    logic            w_id_from_skid;
    logic            w_skid_load;
    logic            w_skid_clear;

    fetch_pkt_t      w_id_pkt;
    logic            w_id_valid_d;

    assign w_pc_inc   = r_pc + PC_STEP;
    assign w_redir_pc = word_align(redirect_pc);

    // Request is live in FETCH/DROP only, and never while reset is held.
    assign w_imem_req = !rst && ((r_state == S_FETCH) || (r_state == S_DROP));

    // An ack only counts against a live request.
    assign w_ack = imem_ack && w_imem_req;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; redirect takes priority over stall and ack data.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (redirect) begin
                    w_state_next = w_ack ? S_FETCH : S_DROP;
                end else if (w_ack && id_valid && stall) begin
                    w_state_next = S_SKID;
                end
            end
            S_SKID: begin
                if (redirect || !stall) begin
                    w_state_next = S_FETCH;
                end
            end
            S_DROP: begin
                if (w_ack) begin
                    w_state_next = S_FETCH;
                end
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    // Datapath control decode for the current state and inputs.
    always_comb begin
        w_pc_sel       = PC_HOLD;
        w_req_sel      = RA_HOLD;
        w_id_load      = 1'b0;
        w_id_clear     = 1'b0;
        w_id_from_skid = 1'b0;
        w_skid_load    = 1'b0;
        w_skid_clear   = 1'b0;

        if (redirect) begin
            w_pc_sel     = PC_REDIR;
            w_id_clear   = 1'b1;
            w_skid_clear = 1'b1;
            case (r_state)
                S_FETCH: if (w_ack) w_req_sel = RA_REDIR;
                S_SKID:  w_req_sel = RA_REDIR;
                S_DROP:  if (w_ack) w_req_sel = RA_REDIR;
                default: w_req_sel = RA_HOLD;
            endcase
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_ack) begin
                        w_pc_sel  = PC_INC;
                        w_req_sel = RA_INC;
                        if (!id_valid || !stall) begin
                            w_id_load = 1'b1;
                        end else begin
                            w_skid_load = 1'b1;
                        end
                    end
                end
                S_SKID: begin
                    if (!stall) begin
                        w_id_load      = 1'b1;
                        w_id_from_skid = 1'b1;
                        w_skid_clear   = 1'b1;
                    end
                end
                S_DROP: begin
                    // Wrong-path data is discarded; re-aim the port at the current PC.
                    if (w_ack) begin
                        w_req_sel = RA_PC;
                    end
                end
                default: w_pc_sel = PC_HOLD;
            endcase
        end
    end

    // PC, request address and skid buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_skid       <= '{instr: NOP_INSTR, pc: RESET_PC};
            r_skid_valid <= 1'b0;
        end else begin
            case (w_pc_sel)
                PC_INC:   r_pc <= w_pc_inc;
                PC_REDIR: r_pc <= w_redir_pc;
                default:  r_pc <= r_pc;
            endcase

            case (w_req_sel)
                RA_INC:   r_req_addr <= w_pc_inc;
                RA_REDIR: r_req_addr <= w_redir_pc;
                RA_PC:    r_req_addr <= r_pc;
                default:  r_req_addr <= r_req_addr;
            endcase

            if (w_skid_load) begin
                r_skid       <= '{instr: imem_rdata, pc: r_pc};
                r_skid_valid <= 1'b1;
            end else if (w_skid_clear) begin
                r_skid_valid <= 1'b0;
            end
        end
    end

    // IF/ID input comes from the skid buffer when draining it, else from memory.
    always_comb begin
        w_id_pkt     = '{instr: imem_rdata, pc: r_pc};
        w_id_valid_d = 1'b1;
        if (w_id_from_skid) begin
            w_id_pkt     = r_skid;
            w_id_valid_d = r_skid_valid;
        end
    end

    riscv_if_id_reg #(
        .RESET_PC (RESET_PC)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_id_load),
        .i_clear    (w_id_clear),
        .i_valid    (w_id_valid_d),
        .i_pkt      (w_id_pkt),
        .o_valid    (id_valid),
        .o_instr    (id_instr),
        .o_pc       (id_pc),
        .o_pc_plus4 (id_pc_plus4)
    );

    assign imem_req  = w_imem_req;
    assign imem_addr = r_req_addr;

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Scoreboard bench for riscv_fetch_stage: directed phases push expected IF/ID
// entries; a negedge monitor pops and compares each newly loaded IF/ID entry.
module tb_riscv_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    riscv_fetch_stage #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4)
    );

    // Memory model: word at address 0 is a bltu, elsewhere {addr[23:0], 8'h13}.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0052_6863;
        return {a[23:0], 8'h13};
    endfunction

    int unsigned lat = 0;
    logic        force_ack = 1'b0;
    logic [7:0]  cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       cnt <= 8'd0;
        else if (imem_req && imem_ack) cnt <= 8'd0;
        else if (imem_req)             cnt <= cnt + 8'd1;
    end

    assign imem_ack   = force_ack | (imem_req && (32'(cnt) >= lat));
    assign imem_rdata = mem_word(imem_addr);

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a valid IF/ID entry that differs from last cycle's is a new delivery.
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc    = 32'h0;
    logic [31:0] prev_instr = 32'h0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (id_valid && (!prev_valid || id_pc !== prev_pc || id_instr !== prev_instr)) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_id: got pc %h instr %h, expected no delivery", id_pc, id_instr);
                end else begin
                    e = sb.pop_front();
                    check32("sb_instr", id_instr, e.instr);
                    check32("sb_pc", id_pc, e.pc);
                    check32("sb_pc_plus4", id_pc_plus4, e.pc + 32'd4);
                end
            end
            prev_valid = id_valid;
            prev_pc    = id_pc;
            prev_instr = id_instr;
        end
    end

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drain check, then hold reset one edge and check reset state.
    task automatic do_reset(input int unsigned l);
        @(negedge clk);
        #1;
        check32("sb_drain", 32'(sb.size()), 32'h0);
        sb.delete();
        rst = 1'b1; redirect = 1'b0; stall = 1'b0; force_ack = 1'b0;
        redirect_pc = 32'h0; lat = l;
        step();
        check32("rst_imem_req", 32'(imem_req), 32'h0);
        check32("rst_id_valid", 32'(id_valid), 32'h0);
        check32("rst_id_instr", id_instr, NOP);
        check32("rst_id_pc", id_pc, 32'h0);
        check32("rst_imem_addr", imem_addr, 32'h0);
    endtask

    task automatic release_rst();
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Phase 1: zero-latency memory, one instruction per cycle.
        do_reset(0);
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
        release_rst();
        step();
        check32("p1_id_valid", 32'(id_valid), 32'h1);
        check32("p1_pc_plus4", id_pc_plus4, 32'h4);
        check32("p1_addr1", imem_addr, 32'h4);
        step();
        check32("p1_addr2", imem_addr, 32'h8);
        step();
        check32("p1_addr3", imem_addr, 32'hC);

        // Phase 2: three-cycle ack latency holds the request stable.
        do_reset(3);
        push_exp(32'h0);
        release_rst();
        for (int i = 0; i < 3; i++) begin
            step();
            check32("p2_wait_valid", 32'(id_valid), 32'h0);
            check32("p2_wait_req", 32'(imem_req), 32'h1);
            check32("p2_wait_addr", imem_addr, 32'h0);
        end
        step();
        check32("p2_ack_valid", 32'(id_valid), 32'h1);
        check32("p2_next_addr", imem_addr, 32'h4);

        // Phase 3: stall while ack arrives parks the word in the skid buffer.
        do_reset(0);
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
        release_rst();
        step();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check32("p3_skid_req", 32'(imem_req), 32'h0);
            check32("p3_skid_id_pc", id_pc, 32'h0);
            check32("p3_skid_valid", 32'(id_valid), 32'h1);
        end
        stall = 1'b0;
        step();
        check32("p3_drain_id_pc", id_pc, 32'h4);
        check32("p3_drain_addr", imem_addr, 32'h8);
        check32("p3_drain_req", 32'(imem_req), 32'h1);
        step();
        check32("p3_next_id_pc", id_pc, 32'h8);

        // Phase 4: redirect while fetch of 8 is outstanding; its data is dropped.
        do_reset(2);
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h10);
        release_rst();
        for (int i = 0; i < 6; i++) step();
        check32("p4_pre_id_pc", id_pc, 32'h4);
        check32("p4_pre_addr", imem_addr, 32'h8);
        redirect = 1'b1; redirect_pc = 32'h10;
        step();
        redirect = 1'b0;
        check32("p4_flush_valid", 32'(id_valid), 32'h0);
        check32("p4_held_addr", imem_addr, 32'h8);
        check32("p4_held_req", 32'(imem_req), 32'h1);
        step(); step();
        check32("p4_new_addr", imem_addr, 32'h10);
        check32("p4_drop_valid", 32'(id_valid), 32'h0);
        step(); step(); step();
        check32("p4_tgt_valid", 32'(id_valid), 32'h1);
        check32("p4_tgt_id_pc", id_pc, 32'h10);

        // Phase 5: redirect beats stall and ack in the same cycle; target realigned.
        do_reset(0);
        push_exp(32'h0); push_exp(32'h10);
        release_rst();
        step();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h13;
        step();
        stall = 1'b0; redirect = 1'b0;
        check32("p5_flush_valid", 32'(id_valid), 32'h0);
        check32("p5_new_addr", imem_addr, 32'h10);
        step();
        check32("p5_tgt_id_pc", id_pc, 32'h10);

        // Phase 6: PC wrap at the top of the address space, then reset mid-wait.
        do_reset(0);
        push_exp(32'h0); push_exp(32'hFFFF_FFFC); push_exp(32'h0);
        release_rst();
        step();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        check32("p6_redir_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        check32("p6_top_id_pc", id_pc, 32'hFFFF_FFFC);
        check32("p6_top_plus4", id_pc_plus4, 32'h0);
        check32("p6_wrap_addr", imem_addr, 32'h0);
        step();
        check32("p6_wrap_id_pc", id_pc, 32'h0);
        lat = 5;
        step(); step();
        check32("p6_wait_req", 32'(imem_req), 32'h1);
        rst = 1'b1; force_ack = 1'b1;
        #1;
        check32("p6_rst_req", 32'(imem_req), 32'h0);
        check32("p6_rst_valid", 32'(id_valid), 32'h0);
        check32("p6_rst_addr", imem_addr, 32'h0);
        step();
        check32("p6_stale_valid", 32'(id_valid), 32'h0);
        check32("p6_stale_id_pc", id_pc, 32'h0);
        check32("p6_rst_drain", 32'(sb.size()), 32'h0);
        force_ack = 1'b0; lat = 0;
        push_exp(32'h0);
        release_rst();
        step();
        check32("p6_restart_valid", 32'(id_valid), 32'h1);
        check32("p6_restart_addr", imem_addr, 32'h4);

        @(negedge clk);
        #1;
        check32("final_drain", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
